// File: rtl/instr_encoder_pkg.sv
// Shared constants for the MIPS instruction encoder:
// primary opcodes, function codes, regimm codes and mnemonic ids.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    LI2
  } state_t;

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // function codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MOVZ  = 6'h0A;
  localparam logic [5:0] F_MOVN  = 6'h0B;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // regimm rt codes
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  // mnemonic ids
  localparam logic [5:0] MN_NOP   = 6'd0;
  localparam logic [5:0] MN_ADD   = 6'd1;
  localparam logic [5:0] MN_ADDU  = 6'd2;
  localparam logic [5:0] MN_SUB   = 6'd3;
  localparam logic [5:0] MN_SUBU  = 6'd4;
  localparam logic [5:0] MN_AND   = 6'd5;
  localparam logic [5:0] MN_OR    = 6'd6;
  localparam logic [5:0] MN_XOR   = 6'd7;
  localparam logic [5:0] MN_NOR   = 6'd8;
  localparam logic [5:0] MN_SLT   = 6'd9;
  localparam logic [5:0] MN_SLTU  = 6'd10;
  localparam logic [5:0] MN_SLL   = 6'd11;
  localparam logic [5:0] MN_SRL   = 6'd12;
  localparam logic [5:0] MN_SRA   = 6'd13;
  localparam logic [5:0] MN_SLLV  = 6'd14;
  localparam logic [5:0] MN_SRLV  = 6'd15;
  localparam logic [5:0] MN_SRAV  = 6'd16;
  localparam logic [5:0] MN_JR    = 6'd17;
  localparam logic [5:0] MN_JALR  = 6'd18;
  localparam logic [5:0] MN_MOVZ  = 6'd19;
  localparam logic [5:0] MN_MOVN  = 6'd20;
  localparam logic [5:0] MN_MULT  = 6'd21;
  localparam logic [5:0] MN_MULTU = 6'd22;
  localparam logic [5:0] MN_DIV   = 6'd23;
  localparam logic [5:0] MN_DIVU  = 6'd24;
  localparam logic [5:0] MN_MFHI  = 6'd25;
  localparam logic [5:0] MN_MFLO  = 6'd26;
  localparam logic [5:0] MN_MTHI  = 6'd27;
  localparam logic [5:0] MN_MTLO  = 6'd28;
  localparam logic [5:0] MN_ADDI  = 6'd29;
  localparam logic [5:0] MN_ADDIU = 6'd30;
  localparam logic [5:0] MN_ANDI  = 6'd31;
  localparam logic [5:0] MN_ORI   = 6'd32;
  localparam logic [5:0] MN_XORI  = 6'd33;
  localparam logic [5:0] MN_SLTI  = 6'd34;
  localparam logic [5:0] MN_SLTIU = 6'd35;
  localparam logic [5:0] MN_LUI   = 6'd36;
  localparam logic [5:0] MN_LB    = 6'd37;
  localparam logic [5:0] MN_LBU   = 6'd38;
  localparam logic [5:0] MN_LH    = 6'd39;
  localparam logic [5:0] MN_LHU   = 6'd40;
  localparam logic [5:0] MN_LW    = 6'd41;
  localparam logic [5:0] MN_SB    = 6'd42;
  localparam logic [5:0] MN_SH    = 6'd43;
  localparam logic [5:0] MN_SW    = 6'd44;
  localparam logic [5:0] MN_BEQ   = 6'd45;
  localparam logic [5:0] MN_BNE   = 6'd46;
  localparam logic [5:0] MN_BLEZ  = 6'd47;
  localparam logic [5:0] MN_BGTZ  = 6'd48;
  localparam logic [5:0] MN_BLTZ  = 6'd49;
  localparam logic [5:0] MN_BGEZ  = 6'd50;
  localparam logic [5:0] MN_J     = 6'd51;
  localparam logic [5:0] MN_JAL   = 6'd52;
  localparam logic [5:0] MN_LI    = 6'd53;

endpackage

// File: rtl/instr_encoder_enc_word.sv
// Combinational mnemonic-to-machine-word encoder.
// li yields a lui/ori pair; unknown ids flag illegal.
module enc_word
  import instr_encoder_pkg::*;
(
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] imm,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        two_words,
  output logic        illegal
);

  logic [31:0] rw;
  logic [31:0] iw;
  logic [31:0] jw;

  assign rw = {6'd0, rs, rt, rd, shamt, 6'd0};
  assign iw = {6'd0, rs, rt, imm[15:0]};
  assign jw = {6'd0, imm[27:2]};

  // select the word template and merge the op/func code
  always_comb begin
    word0     = '0;
    word1     = '0;
    two_words = 1'b0;
    illegal   = 1'b0;
    unique case (mnem)
      MN_NOP:   word0 = '0;
      MN_ADD:   word0 = rw | {26'd0, F_ADD};
      MN_ADDU:  word0 = rw | {26'd0, F_ADDU};
      MN_SUB:   word0 = rw | {26'd0, F_SUB};
      MN_SUBU:  word0 = rw | {26'd0, F_SUBU};
      MN_AND:   word0 = rw | {26'd0, F_AND};
      MN_OR:    word0 = rw | {26'd0, F_OR};
      MN_XOR:   word0 = rw | {26'd0, F_XOR};
      MN_NOR:   word0 = rw | {26'd0, F_NOR};
      MN_SLT:   word0 = rw | {26'd0, F_SLT};
      MN_SLTU:  word0 = rw | {26'd0, F_SLTU};
      MN_SLL:   word0 = rw | {26'd0, F_SLL};
      MN_SRL:   word0 = rw | {26'd0, F_SRL};
      MN_SRA:   word0 = rw | {26'd0, F_SRA};
      MN_SLLV:  word0 = rw | {26'd0, F_SLLV};
      MN_SRLV:  word0 = rw | {26'd0, F_SRLV};
      MN_SRAV:  word0 = rw | {26'd0, F_SRAV};
      MN_JR:    word0 = rw | {26'd0, F_JR};
      MN_JALR:  word0 = rw | {26'd0, F_JALR};
      MN_MOVZ:  word0 = rw | {26'd0, F_MOVZ};
      MN_MOVN:  word0 = rw | {26'd0, F_MOVN};
      MN_MULT:  word0 = rw | {26'd0, F_MULT};
      MN_MULTU: word0 = rw | {26'd0, F_MULTU};
      MN_DIV:   word0 = rw | {26'd0, F_DIV};
      MN_DIVU:  word0 = rw | {26'd0, F_DIVU};
      MN_MFHI:  word0 = rw | {26'd0, F_MFHI};
      MN_MFLO:  word0 = rw | {26'd0, F_MFLO};
      MN_MTHI:  word0 = rw | {26'd0, F_MTHI};
      MN_MTLO:  word0 = rw | {26'd0, F_MTLO};
      MN_ADDI:  word0 = iw | {OP_ADDI, 26'd0};
      MN_ADDIU: word0 = iw | {OP_ADDIU, 26'd0};
      MN_ANDI:  word0 = iw | {OP_ANDI, 26'd0};
      MN_ORI:   word0 = iw | {OP_ORI, 26'd0};
      MN_XORI:  word0 = iw | {OP_XORI, 26'd0};
      MN_SLTI:  word0 = iw | {OP_SLTI, 26'd0};
      MN_SLTIU: word0 = iw | {OP_SLTIU, 26'd0};
      MN_LUI:   word0 = iw | {OP_LUI, 26'd0};
      MN_LB:    word0 = iw | {OP_LB, 26'd0};
      MN_LBU:   word0 = iw | {OP_LBU, 26'd0};
      MN_LH:    word0 = iw | {OP_LH, 26'd0};
      MN_LHU:   word0 = iw | {OP_LHU, 26'd0};
      MN_LW:    word0 = iw | {OP_LW, 26'd0};
      MN_SB:    word0 = iw | {OP_SB, 26'd0};
      MN_SH:    word0 = iw | {OP_SH, 26'd0};
      MN_SW:    word0 = iw | {OP_SW, 26'd0};
      MN_BEQ:   word0 = iw | {OP_BEQ, 26'd0};
      MN_BNE:   word0 = iw | {OP_BNE, 26'd0};
      MN_BLEZ:  word0 = iw | {OP_BLEZ, 26'd0};
      MN_BGTZ:  word0 = iw | {OP_BGTZ, 26'd0};
      MN_BLTZ:  word0 = {OP_REGIMM, rs, RT_BLTZ, imm[15:0]};
      MN_BGEZ:  word0 = {OP_REGIMM, rs, RT_BGEZ, imm[15:0]};
      MN_J:     word0 = jw | {OP_J, 26'd0};
      MN_JAL:   word0 = jw | {OP_JAL, 26'd0};
      MN_LI: begin
        word0     = {OP_LUI, 5'd0, rt, imm[31:16]};
        word1     = {OP_ORI, rt, rt, imm[15:0]};
        two_words = 1'b1;
      end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instructions into instruction memory.
// Holds the li pending word, the word counter and the write port.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          IM_DEPTH  = 4096,
  parameter int          CNT_W     = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_mnem,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_shamt,
  input  logic [31:0]      req_imm,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IM_DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t      state;
  logic [31:0] pend;
  logic [31:0] w0;
  logic [31:0] w1;
  logic        two;
  logic        ill;
  logic        accept;
  logic        li_room;
  logic        bad;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0] addr_nxt;

  enc_word u_enc (
    .mnem      (req_mnem),
    .rs        (req_rs),
    .rt        (req_rt),
    .rd        (req_rd),
    .shamt     (req_shamt),
    .imm       (req_imm),
    .word0     (w0),
    .word1     (w1),
    .two_words (two),
    .illegal   (ill)
  );

  // count already includes the word on the port, so this
  // leaves no room for an overrun
  assign req_ready = (state != LI2) && (count < DEPTH_C);
  assign accept    = req_valid & req_ready;
  assign li_room   = count < (DEPTH_C - ONE);
  assign bad       = ill || (two && !li_room);
  assign cnt_inc   = full ? count : count + ONE;
  assign addr_nxt  = BASE_ADDR + (32'(count) << 2);
  assign full      = count == DEPTH_C;

  // FSM, pending ori, counter and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= '0;
      im_we    <= 1'b0;
      im_addr  <= BASE_ADDR;
      im_wdata <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else if (state == LI2) begin
      im_we    <= 1'b1;
      im_addr  <= addr_nxt;
      im_wdata <= pend;
      count    <= cnt_inc;
      state    <= EMIT;
    end else if (accept && bad) begin
      err   <= 1'b1;
      im_we <= 1'b0;
      state <= IDLE;
    end else if (accept) begin
      im_we    <= 1'b1;
      im_addr  <= addr_nxt;
      im_wdata <= w0;
      count    <= cnt_inc;
      if (two) begin
        pend  <= w1;
        state <= LI2;
      end else begin
        state <= EMIT;
      end
    end else begin
      im_we <= 1'b0;
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, corner sequences
// and random traffic against an arithmetic reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  typedef struct {
    bit          v;
    logic [5:0]  m;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        r;
    logic [31:0] exp;
  } vec_t;

  localparam int K_X = 0;
  localparam int K_R = 1;
  localparam int K_I = 2;
  localparam int K_B = 3;
  localparam int K_J = 4;
  localparam int K_N = 5;
  localparam int K_L = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic [5:0]  req_mnem;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [31:0] req_imm;

  logic        a_ready, a_we, a_full, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [12:0] a_count;
  logic        b_ready, b_we, b_full, b_err;
  logic [31:0] b_addr, b_wdata;
  logic [2:0]  b_count;

  instr_encoder dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(a_ready), .req_mnem(req_mnem),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm),
    .im_we(a_we), .im_addr(a_addr), .im_wdata(a_wdata),
    .count(a_count), .full(a_full), .err(a_err)
  );

  instr_encoder #(.IM_DEPTH(4), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(b_ready), .req_mnem(req_mnem),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm),
    .im_we(b_we), .im_addr(b_addr), .im_wdata(b_wdata),
    .count(b_count), .full(b_full), .err(b_err)
  );

  bit          sel;
  logic        o_ready, o_we, o_full, o_err;
  logic [31:0] o_addr, o_wdata, o_count;

  always_comb begin
    o_ready = sel ? b_ready : a_ready;
    o_we    = sel ? b_we : a_we;
    o_full  = sel ? b_full : a_full;
    o_err   = sel ? b_err : a_err;
    o_addr  = sel ? b_addr : a_addr;
    o_wdata = sel ? b_wdata : a_wdata;
    o_count = sel ? 32'(b_count) : 32'(a_count);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int kind [64];
  int code [64];

  int unsigned depth;
  int unsigned m_cnt;
  bit          m_err;
  bit          m_pv;
  logic [31:0] m_pw;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic def(logic [5:0] m, int k, int c);
    kind[m] = k;
    code[m] = c;
  endtask

  function automatic req_t mk(logic [5:0] m, int rs, int rt,
                              int rd, int sh, logic [31:0] imm);
    req_t r;
    r.v = 1'b1; r.m = m; r.imm = imm;
    r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.sh = 5'(sh);
    return r;
  endfunction

  // reference encoding straight from MIPS field layouts
  task automatic ref_enc(input req_t r, output bit bad,
                         output bit two, output logic [31:0] w0,
                         output logic [31:0] w1);
    int unsigned rs, rt, rd, sh, c, imm;
    rs = r.rs; rt = r.rt; rd = r.rd; sh = r.sh;
    c = code[r.m]; imm = r.imm;
    bad = 0; two = 0; w0 = 0; w1 = 0;
    case (kind[r.m])
      K_R: w0 = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | c;
      K_I: w0 = (c << 26) | (rs << 21) | (rt << 16) | (imm % 65536);
      K_B: w0 = (1 << 26) | (rs << 21) | (c << 16) | (imm % 65536);
      K_J: w0 = (c << 26) | ((imm / 4) % (1 << 26));
      K_N: w0 = 0;
      K_L: begin
        two = 1;
        w0 = (15 << 26) | (rt << 16) | (imm / 65536);
        w1 = (13 << 26) | (rt << 21) | (rt << 16) | (imm % 65536);
      end
      default: bad = 1;
    endcase
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_we", 32'(o_we), 0);
    chk("rst_addr", o_addr, 32'h3000);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_count", o_count, 0);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_err", 32'(o_err), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_cnt = 0; m_err = 0; m_pv = 0; m_pw = 0;
  endtask

  // one clock: drive request, predict, then check outputs
  task automatic step(input req_t r);
    bit          rdy, we, bad, two;
    logic [31:0] w0, w1, data, addr;
    req_valid = r.v; req_mnem = r.m; req_rs = r.rs;
    req_rt = r.rt; req_rd = r.rd; req_shamt = r.sh;
    req_imm = r.imm;
    rdy = !m_pv && (m_cnt < depth);
    chk("ready", 32'(o_ready), 32'(rdy));
    we = 0; data = 0;
    if (m_pv) begin
      we = 1; data = m_pw; m_pv = 0;
    end else if (r.v && rdy) begin
      ref_enc(r, bad, two, w0, w1);
      if (bad || (two && depth - m_cnt < 2)) begin
        m_err = 1;
      end else begin
        we = 1; data = w0;
        if (two) begin
          m_pv = 1; m_pw = w1;
        end
      end
    end
    addr = 32'h3000 + 4 * m_cnt;
    if (we) m_cnt++;
    @(posedge clk); #1;
    chk("im_we", 32'(o_we), 32'(we));
    if (we) begin
      chk("im_addr", o_addr, addr);
      chk("im_wdata", o_wdata, data);
    end
    chk("count", o_count, m_cnt);
    chk("full", 32'(o_full), 32'(m_cnt == depth));
    chk("err", 32'(o_err), 32'(m_err));
  endtask

  function automatic req_t idle();
    req_t r;
    r = mk(MN_NOP, 0, 0, 0, 0, 0);
    r.v = 1'b0;
    return r;
  endfunction

  function automatic req_t rnd();
    req_t r;
    int   m;
    m = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 53)
                                   : $urandom_range(0, 63);
    r = mk(6'(m), $urandom, $urandom, $urandom, $urandom, $urandom);
    r.v = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  vec_t vecs [12];

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_mnem = 0;
    req_rs = 0; req_rt = 0; req_rd = 0; req_shamt = 0; req_imm = 0;
    sel = 0; depth = 4096;

    for (int i = 0; i < 64; i++) def(6'(i), K_X, 0);
    def(MN_NOP, K_N, 0);
    def(MN_ADD, K_R, 'h20);   def(MN_ADDU, K_R, 'h21);
    def(MN_SUB, K_R, 'h22);   def(MN_SUBU, K_R, 'h23);
    def(MN_AND, K_R, 'h24);   def(MN_OR, K_R, 'h25);
    def(MN_XOR, K_R, 'h26);   def(MN_NOR, K_R, 'h27);
    def(MN_SLT, K_R, 'h2A);   def(MN_SLTU, K_R, 'h2B);
    def(MN_SLL, K_R, 'h00);   def(MN_SRL, K_R, 'h02);
    def(MN_SRA, K_R, 'h03);   def(MN_SLLV, K_R, 'h04);
    def(MN_SRLV, K_R, 'h06);  def(MN_SRAV, K_R, 'h07);
    def(MN_JR, K_R, 'h08);    def(MN_JALR, K_R, 'h09);
    def(MN_MOVZ, K_R, 'h0A);  def(MN_MOVN, K_R, 'h0B);
    def(MN_MULT, K_R, 'h18);  def(MN_MULTU, K_R, 'h19);
    def(MN_DIV, K_R, 'h1A);   def(MN_DIVU, K_R, 'h1B);
    def(MN_MFHI, K_R, 'h10);  def(MN_MFLO, K_R, 'h12);
    def(MN_MTHI, K_R, 'h11);  def(MN_MTLO, K_R, 'h13);
    def(MN_ADDI, K_I, 'h08);  def(MN_ADDIU, K_I, 'h09);
    def(MN_ANDI, K_I, 'h0C);  def(MN_ORI, K_I, 'h0D);
    def(MN_XORI, K_I, 'h0E);  def(MN_SLTI, K_I, 'h0A);
    def(MN_SLTIU, K_I, 'h0B); def(MN_LUI, K_I, 'h0F);
    def(MN_LB, K_I, 'h20);    def(MN_LBU, K_I, 'h24);
    def(MN_LH, K_I, 'h21);    def(MN_LHU, K_I, 'h25);
    def(MN_LW, K_I, 'h23);    def(MN_SB, K_I, 'h28);
    def(MN_SH, K_I, 'h29);    def(MN_SW, K_I, 'h2B);
    def(MN_BEQ, K_I, 'h04);   def(MN_BNE, K_I, 'h05);
    def(MN_BLEZ, K_I, 'h06);  def(MN_BGTZ, K_I, 'h07);
    def(MN_BLTZ, K_B, 0);     def(MN_BGEZ, K_B, 1);
    def(MN_J, K_J, 'h02);     def(MN_JAL, K_J, 'h03);
    def(MN_LI, K_L, 0);

    vecs[0]  = '{mk(MN_ADDU, 1, 2, 3, 0, 0), 32'h0022_1821};
    vecs[1]  = '{mk(MN_ORI, 0, 1, 0, 0, 32'h1234), 32'h3401_1234};
    vecs[2]  = '{mk(MN_J, 0, 0, 0, 0, 32'h3010), 32'h0800_0C04};
    vecs[3]  = '{mk(MN_BGEZ, 4, 0, 0, 0, 32'hFFFE), 32'h0481_FFFE};
    vecs[4]  = '{mk(MN_SW, 29, 5, 0, 0, 8), 32'hAFA5_0008};
    vecs[5]  = '{mk(MN_LW, 3, 2, 0, 0, 32'hFFFC), 32'h8C62_FFFC};
    vecs[6]  = '{mk(MN_SLL, 0, 1, 2, 4, 0), 32'h0001_1100};
    vecs[7]  = '{mk(MN_JAL, 0, 0, 0, 0, 32'h0040_0000), 32'h0C10_0000};
    vecs[8]  = '{mk(MN_MFLO, 0, 0, 4, 0, 0), 32'h0000_2012};
    vecs[9]  = '{mk(MN_NOP, 0, 0, 0, 0, 0), 32'h0000_0000};
    vecs[10] = '{mk(MN_BLTZ, 7, 0, 0, 0, 32'h10), 32'h04E0_0010};
    vecs[11] = '{mk(MN_LUI, 0, 3, 0, 0, 32'hABCD), 32'h3C03_ABCD};

    // vector table, back-to-back on the full-size instance
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].r);
      chk($sformatf("vec%0d", i), o_wdata, vecs[i].exp);
    end
    step(idle());

    // li expansion with a held request during the ori cycle
    do_reset();
    step(mk(MN_LI, 0, 8, 0, 0, 32'h1234_5678));
    chk("li_lui", o_wdata, 32'h3C08_1234);
    chk("li_lui_addr", o_addr, 32'h3000);
    step(mk(MN_ADDU, 1, 2, 3, 0, 0));
    chk("li_ori", o_wdata, 32'h3508_5678);
    step(mk(MN_ADDU, 1, 2, 3, 0, 0));
    chk("li_next_addr", o_addr, 32'h3008);
    step(idle());

    // illegal mnemonic, then reset while ori is pending
    step(mk(6'h3F, 0, 0, 0, 0, 0));
    chk("illegal_err", 32'(o_err), 1);
    do_reset();
    step(mk(MN_LI, 0, 9, 0, 0, 32'hCAFE_BABE));
    do_reset();
    step(mk(MN_ADDU, 1, 2, 3, 0, 0));
    chk("post_rst_addr", o_addr, 32'h3000);
    step(idle());

    // random traffic on the full-size instance
    for (int i = 0; i < 400; i++) step(rnd());
    step(idle());

    // depth-4 instance: fill, overflow, li edge cases
    sel = 1; depth = 4;
    do_reset();
    for (int i = 0; i < 5; i++) step(mk(MN_ADDU, i, 2, 3, 0, 0));
    chk("fill_full", 32'(o_full), 1);
    chk("fill_count", o_count, 4);
    do_reset();
    for (int i = 0; i < 3; i++) step(mk(MN_ADDU, 1, i, 3, 0, 0));
    step(mk(MN_LI, 0, 4, 0, 0, 32'h1111_2222));
    chk("li1_err", 32'(o_err), 1);
    chk("li1_we", 32'(o_we), 0);
    do_reset();
    for (int i = 0; i < 2; i++) step(mk(MN_ADDU, 1, i, 3, 0, 0));
    step(mk(MN_LI, 0, 4, 0, 0, 32'h1111_2222));
    step(mk(MN_ADDU, 1, 2, 3, 0, 0));
    step(mk(MN_ADDU, 1, 2, 3, 0, 0));
    chk("li2_err", 32'(o_err), 0);

    // random traffic on the small instance with frequent resets
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) do_reset();
      step(rnd());
    end
    step(idle());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
